// File: rtl/execute_stage_pkg.sv
// Shared opcode constants, the HALT word and FSM state encodings for the execute stage.
package execute_stage_pkg;

    localparam logic [3:0]  OP_NOP    = 4'h0;
    localparam logic [3:0]  OP_LDI    = 4'h1;
    localparam logic [3:0]  OP_ADD    = 4'h2;
    localparam logic [3:0]  OP_SUB    = 4'h3;
    localparam logic [3:0]  OP_AND    = 4'h4;
    localparam logic [3:0]  OP_OR     = 4'h5;
    localparam logic [3:0]  OP_MUL    = 4'h6;
    localparam logic [3:0]  OP_MAC    = 4'h7;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMult = 2'd1,
        StHalt = 2'd2
    } state_e;

    // Opcodes 8..E are undefined; F-prefixed words are NOP or HALT.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'h8) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/execute_stage_regfile.sv
// Register file: three combinational read ports, one synchronous write port, async clear.
module execute_stage_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra1_i,
    input  logic [AW-1:0]     ra2_i,
    input  logic [AW-1:0]     ra3_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] rd3_o,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [NREGS];

    // Storage: cleared on reset, single write per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rd1_o = regs_q[ra1_i];
    assign rd2_o = regs_q[ra2_i];
    assign rd3_o = regs_q[ra3_i];

endmodule

// File: rtl/execute_stage.sv
// Execute stage: decode, single-cycle ALU, 8-step shift-add MUL/MAC and a sticky HALT.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_pc,
    input  logic [15:0]       in_instr,
    output logic              wb_valid,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       wb_pc,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned AW = 4;

    state_e            state_q;
    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
    logic [2:0]        step_q;
    logic [AW-1:0]     rd_q;
    logic [15:0]       pc_q;
    logic              wb_valid_q, halted_q, illegal_q;
    logic [AW-1:0]     wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [15:0]       wb_pc_q;

    logic [3:0]        op;
    logic [AW-1:0]     rd_a, rs1_a, rs2_a, ra3;
    logic              accept, is_alu, is_mul, is_halt;
    logic [DATA_W-1:0] rd1, rd2, rd3, alu_res, acc_next;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign op      = in_instr[15:12];
    assign rd_a    = in_instr[11:8];
    assign rs1_a   = in_instr[7:4];
    assign rs2_a   = in_instr[3:0];
    assign in_ready = (state_q == StIdle);
    assign accept  = in_valid && in_ready;
    assign is_alu  = (op >= OP_LDI) && (op <= OP_OR);
    assign is_mul  = (op == OP_MUL) || (op == OP_MAC);
    assign is_halt = (in_instr == HALT_WORD);

    // Third read port serves MAC's accumulator seed at accept, debug otherwise.
    assign ra3      = (accept && op == OP_MAC) ? rd_a : dbg_addr;
    assign dbg_data = rd3;

    execute_stage_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra1_i   (rs1_a),
        .ra2_i   (rs2_a),
        .ra3_i   (ra3),
        .rd1_o   (rd1),
        .rd2_o   (rd2),
        .rd3_o   (rd3),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata)
    );

    // Single-cycle ALU result for the presented instruction.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_LDI:  alu_res = DATA_W'(in_instr[7:0]);
            OP_ADD:  alu_res = rd1 + rd2;
            OP_SUB:  alu_res = rd1 - rd2;
            OP_AND:  alu_res = rd1 & rd2;
            OP_OR:   alu_res = rd1 | rd2;
            default: alu_res = '0;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Write port: final multiply step wins, otherwise an accepted ALU op.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_a;
        rf_wdata = alu_res;
        if (state_q == StMult && step_q == 3'd7) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = acc_next;
        end else if (accept && is_alu) begin
            rf_we = 1'b1;
        end
    end

    // Control FSM, multiplier datapath and registered status/writeback outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_pc_q    <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (is_alu) begin
                            wb_valid_q <= 1'b1;
                            wb_addr_q  <= rd_a;
                            wb_data_q  <= alu_res;
                            wb_pc_q    <= in_pc;
                        end else if (is_mul) begin
                            state_q  <= StMult;
                            mcand_q  <= rd1;
                            mplier_q <= rd2;
                            acc_q    <= (op == OP_MAC) ? rd3 : '0;
                            step_q   <= '0;
                            rd_q     <= rd_a;
                            pc_q     <= in_pc;
                        end else if (is_halt) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end else if (is_illegal_op(op)) begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                StMult: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    step_q   <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        state_q    <= StIdle;
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= rd_q;
                        wb_data_q  <= acc_next;
                        wb_pc_q    <= pc_q;
                    end
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign wb_pc    = wb_pc_q;
    assign busy     = (state_q == StMult);
    assign halted   = halted_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage with an instruction-level reference model.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [15:0] in_instr;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [15:0] wb_pc;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] m_regs [16];

    execute_stage #(
        .DATA_W (8),
        .NREGS  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_pc    (wb_pc),
        .busy     (busy),
        .halted   (halted),
        .illegal  (illegal),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Architectural model: executes one instruction on m_regs.
    task automatic model_exec(input logic [15:0] instr, output bit wr, output logic [3:0] addr,
                              output logic [7:0] data, output bit multi);
        int a, b, d;
        wr    = 0;
        multi = 0;
        addr  = instr[11:8];
        data  = 8'h00;
        a = int'(m_regs[instr[7:4]]);
        b = int'(m_regs[instr[3:0]]);
        d = int'(m_regs[instr[11:8]]);
        case (instr[15:12])
            4'h1: begin wr = 1; data = instr[7:0]; end
            4'h2: begin wr = 1; data = 8'((a + b) % 256); end
            4'h3: begin wr = 1; data = 8'((a - b + 256) % 256); end
            4'h4: begin wr = 1; data = 8'(a & b); end
            4'h5: begin wr = 1; data = 8'(a | b); end
            4'h6: begin wr = 1; multi = 1; data = 8'((a * b) % 256); end
            4'h7: begin wr = 1; multi = 1; data = 8'((d + a * b) % 256); end
            default: wr = 0;
        endcase
        if (wr) m_regs[addr] = data;
    endtask

    // Present one instruction until accepted (bounded); returns 1ns after the accept edge.
    task automatic send(input logic [15:0] instr, input logic [15:0] pc);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = instr;
            in_pc    = pc;
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout instr=%h: in_ready never high", instr);
        end
    endtask

    task automatic load(input logic [3:0] r, input logic [7:0] v);
        bit wr, multi;
        logic [3:0] a;
        logic [7:0] d;
        model_exec({4'h1, r, v}, wr, a, d, multi);
        send({4'h1, r, v}, 16'h0000);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({wb_valid, wb_addr, wb_data, wb_pc, busy, halted, illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wb=%b/%h/%h/%h busy=%b halted=%b illegal=%b, want 0",
                     wb_valid, wb_addr, wb_data, wb_pc, busy, halted, illegal);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            n_checks++;
            if (dbg_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg r%0d: got %h want 00", i, dbg_data);
            end
        end
    endtask

    task automatic test_ldi();
        bit wr, multi;
        logic [3:0] a;
        logic [7:0] d;
        model_exec(16'h1105, wr, a, d, multi);
        send(16'h1105, 16'h0010);
        n_checks++;
        if ({wb_valid, wb_addr, wb_data, wb_pc} !== {1'b1, 4'h1, 8'h05, 16'h0010}) begin
            n_fail++;
            $display("FAIL ldi_wb: got v=%b a=%h d=%h pc=%h want 1/1/05/0010",
                     wb_valid, wb_addr, wb_data, wb_pc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ldi_wb_pulse: wb_valid got %b want 0 on second cycle", wb_valid);
        end
        dbg_addr = 4'h1;
        #1;
        n_checks++;
        if (dbg_data !== 8'h05) begin
            n_fail++;
            $display("FAIL ldi_dbg: got %h want 05", dbg_data);
        end
    endtask

    task automatic test_wrap();
        bit wr, multi;
        logic [3:0] a;
        logic [7:0] d;
        load(4'h1, 8'hF0);
        load(4'h2, 8'h20);
        model_exec(16'h2312, wr, a, d, multi);
        send(16'h2312, 16'h0020);
        n_checks++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 4'h3, 8'h10}) begin
            n_fail++;
            $display("FAIL add_wrap: got v=%b a=%h d=%h want 1/3/10", wb_valid, wb_addr, wb_data);
        end
        model_exec(16'h3421, wr, a, d, multi);
        send(16'h3421, 16'h0021);
        n_checks++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 4'h4, 8'h30}) begin
            n_fail++;
            $display("FAIL sub_wrap: got v=%b a=%h d=%h want 1/4/30", wb_valid, wb_addr, wb_data);
        end
    endtask

    // MUL accepted at edge N with an ADD held on the bus: ADD must land at N+9.
    task automatic test_mul_back_to_back();
        bit wr, multi;
        logic [3:0] a;
        logic [7:0] d;
        load(4'h1, 8'h0D);
        load(4'h2, 8'h0B);
        model_exec(16'h6512, wr, a, d, multi);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 16'h6512;
        in_pc    = 16'h0100;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_ready_before: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_instr = 16'h2712;
        in_pc    = 16'h0101;
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (k < 8 && {wb_valid, in_ready, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL mul_wait k=%0d: got wb=%b ready=%b busy=%b want 0/0/1",
                         k, wb_valid, in_ready, busy);
            end else if (k == 8 && !(wb_valid === 1'b0 && in_ready === 1'b0)) begin
                n_fail++;
                $display("FAIL mul_wait k=8: got wb=%b ready=%b before last step", wb_valid,
                         in_ready);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if ({wb_valid, wb_addr, wb_data, wb_pc} !== {1'b1, 4'h5, 8'h8F, 16'h0100}) begin
            n_fail++;
            $display("FAIL mul_wb: got v=%b a=%h d=%h pc=%h want 1/5/8F/0100",
                     wb_valid, wb_addr, wb_data, wb_pc);
        end
        model_exec(16'h2712, wr, a, d, multi);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if ({wb_valid, wb_addr, wb_data, wb_pc} !== {1'b1, 4'h7, 8'h18, 16'h0101}) begin
            n_fail++;
            $display("FAIL b2b_add_wb: got v=%b a=%h d=%h pc=%h want 1/7/18/0101",
                     wb_valid, wb_addr, wb_data, wb_pc);
        end
        dbg_addr = 4'h5;
        #1;
        n_checks++;
        if (dbg_data !== 8'h8F) begin
            n_fail++;
            $display("FAIL mul_dbg r5: got %h want 8F", dbg_data);
        end
    endtask

    task automatic test_mac();
        bit wr, multi;
        logic [3:0] a;
        logic [7:0] d;
        load(4'h6, 8'h10);
        load(4'h1, 8'h03);
        load(4'h2, 8'h04);
        model_exec(16'h7612, wr, a, d, multi);
        send(16'h7612, 16'h0200);
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if ({wb_valid, wb_addr, wb_data, wb_pc} !== {1'b1, 4'h6, 8'h1C, 16'h0200}) begin
            n_fail++;
            $display("FAIL mac_wb: got v=%b a=%h d=%h pc=%h want 1/6/1C/0200",
                     wb_valid, wb_addr, wb_data, wb_pc);
        end
    endtask

    task automatic test_illegal_nop();
        n_checks++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_before: got %b want 0", illegal);
        end
        send(16'h8000, 16'h0300);
        n_checks++;
        if ({wb_valid, illegal, in_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL illegal_op: got wb=%b illegal=%b ready=%b want 0/1/1",
                     wb_valid, illegal, in_ready);
        end
        send(16'hF000, 16'h0301);
        n_checks++;
        if ({wb_valid, halted, in_ready, busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL f000_nop: got wb=%b halted=%b ready=%b busy=%b want 0/0/1/0",
                     wb_valid, halted, in_ready, busy);
        end
        send(16'h0123, 16'h0302);
        n_checks++;
        if ({wb_valid, illegal} !== 2'b01) begin
            n_fail++;
            $display("FAIL nop_sticky: got wb=%b illegal=%b want 0/1", wb_valid, illegal);
        end
    endtask

    task automatic test_random();
        bit wr, multi;
        logic [3:0] a;
        logic [7:0] d;
        logic [15:0] instr, pc;
        logic [3:0] r;
        for (int n = 0; n < 150; n++) begin
            instr = {4'($urandom_range(0, 7)), 12'($urandom)};
            pc    = 16'($urandom);
            model_exec(instr, wr, a, d, multi);
            send(instr, pc);
            if (multi) begin
                repeat (8) @(posedge clk);
                #1;
            end
            n_checks++;
            if (wb_valid !== wr || (wr && {wb_addr, wb_data, wb_pc} !== {a, d, pc})) begin
                n_fail++;
                $display("FAIL rand_wb instr=%h: got v=%b a=%h d=%h pc=%h want %b/%h/%h/%h",
                         instr, wb_valid, wb_addr, wb_data, wb_pc, wr, a, d, pc);
            end
            r = 4'($urandom);
            dbg_addr = r;
            #1;
            n_checks++;
            if (dbg_data !== m_regs[r]) begin
                n_fail++;
                $display("FAIL rand_reg r%0d: got %h want %h", r, dbg_data, m_regs[r]);
            end
        end
    endtask

    task automatic test_mul_reset();
        int bad = 0;
        do_reset();
        load(4'h1, 8'h0D);
        load(4'h2, 8'h0B);
        send(16'h6512, 16'h0400);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        #1;
        dbg_addr = 4'h1;
        #1;
        n_checks++;
        if ({busy, in_ready, wb_valid, dbg_data} !== {3'b010, 8'h00}) begin
            n_fail++;
            $display("FAIL mul_abort_async: got busy=%b ready=%b wb=%b r1=%h want 0/1/0/00",
                     busy, in_ready, wb_valid, dbg_data);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (wb_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mul_abort_wb: wb_valid seen %0d times, want 0", bad);
        end
        dbg_addr = 4'h5;
        #1;
        n_checks++;
        if (dbg_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mul_abort_r5: got %h want 00", dbg_data);
        end
    endtask

    task automatic test_halt();
        int bad = 0;
        load(4'h7, 8'h55);
        send(16'hFFFF, 16'h0500);
        n_checks++;
        if ({halted, in_ready, wb_valid, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL halt_enter: got halted=%b ready=%b wb=%b busy=%b want 1/0/0/0",
                     halted, in_ready, wb_valid, busy);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 16'h17AA;
        in_pc    = 16'h0501;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if ({wb_valid, in_ready, halted} !== 3'b001) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_ignore: %0d cycles not frozen, want 0", bad);
        end
        dbg_addr = 4'h7;
        #1;
        n_checks++;
        if (dbg_data !== 8'h55) begin
            n_fail++;
            $display("FAIL halt_r7: got %h want 55", dbg_data);
        end
        do_reset();
        #1;
        n_checks++;
        if ({halted, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL halt_reset: got halted=%b ready=%b want 0/1", halted, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            if (dbg_data !== 8'h00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_reset_regs: %0d nonzero regs, want 0", bad);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_pc    = 16'h0000;
        in_instr = 16'h0000;
        dbg_addr = 4'h0;
        test_reset();
        test_ldi();
        test_wrap();
        test_mul_back_to_back();
        test_mac();
        test_illegal_nop();
        test_random();
        test_mul_reset();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
